io_timer_gpio: RTL

//  Memory-mapped I/O peripheral on the CPU io bus, downstream of the memory/IO controller.

---
 rtl/io_pkg.sv | 12 +
 rtl/io_timer.sv | 41 ++++
 rtl/io_timer_gpio.sv | 64 ++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: register word indices and CTRL bit positions for the io timer/GPIO block.
package io_pkg;
   localparam logic [5:0] IO_LED    = 6'h00;
   localparam logic [5:0] IO_SW     = 6'h01;
   localparam logic [5:0] IO_CTRL   = 6'h02;
   localparam logic [5:0] IO_LOAD   = 6'h03;
   localparam logic [5:0] IO_COUNT  = 6'h04;
   localparam logic [5:0] IO_STATUS = 6'h05;
   localparam int CTRL_EN  = 0;
   localparam int CTRL_AR  = 1;
   localparam int CTRL_IRQ = 2;
endpackage

// File: rtl/io_timer.sv
// io_timer: prescaled 32-bit down counter with auto-reload, one-shot stop and sticky expiry.
module io_timer
   import io_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrlWe,
   input  logic        loadWe,
   input  logic        statusClr,
   input  logic [31:0] wtData,
   output logic [2:0]  ctrl,
   output logic [31:0] load,
   output logic [31:0] count,
   output logic        expired
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] presc;
   logic tick, expire;
   assign tick   = ctrl[CTRL_EN] && presc == PW'(PRESCALE - 1);
   assign expire = tick && count == '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         presc   <= '0;
         ctrl    <= '0;
         load    <= '0;
         count   <= '0;
         expired <= 1'b0;
      end else begin
         presc <= (loadWe || !ctrl[CTRL_EN] || tick) ? '0 : presc + 1'b1;
         // a CTRL write overrides the one-shot auto-clear of en
         if (ctrlWe) ctrl <= wtData[2:0];
         else if (expire && !ctrl[CTRL_AR]) ctrl[CTRL_EN] <= 1'b0;
         if (loadWe) load <= wtData;
         if (loadWe) count <= wtData;
         else if (tick) count <= count != '0 ? count - 1 : ctrl[CTRL_AR] ? load : count;
         if (expire) expired <= 1'b1;
         else if (statusClr) expired <= 1'b0;
      end
endmodule

// File: rtl/io_timer_gpio.sv
// io_timer_gpio: io-bus peripheral with LED register, synchronised switches and a timer.
module io_timer_gpio
   import io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LED_W     = 16,
   parameter int          SW_W      = 16,
   parameter int          PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ioCe,
   input  logic             ioWr,
   input  logic [31:0]      ioAddr,
   input  logic [31:0]      ioWtData,
   output logic [31:0]      ioRdData,
   input  logic [SW_W-1:0]  sw_i,
   output logic [LED_W-1:0] led_o,
   output logic             irq_o
);
   logic hit, we;
   logic [5:0] idx;
   logic [LED_W-1:0] led;
   logic [SW_W-1:0] swMeta, swSync;
   logic [2:0] ctrl;
   logic [31:0] load, count;
   logic expired;
   logic unusedBits;
   assign unusedBits = ^{ioAddr[1:0], BASE_ADDR[7:0]};
   assign hit = ioCe && ioAddr[31:8] == BASE_ADDR[31:8];
   assign we  = hit && ioWr;
   assign idx = ioAddr[7:2];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         led    <= '0;
         swMeta <= '0;
         swSync <= '0;
      end else begin
         swMeta <= sw_i;
         swSync <= swMeta;
         if (we && idx == IO_LED) led <= ioWtData[LED_W-1:0];
      end
   io_timer #(.PRESCALE(PRESCALE)) uTimer (
      .clk      (clk),
      .rst      (rst),
      .ctrlWe   (we && idx == IO_CTRL),
      .loadWe   (we && idx == IO_LOAD),
      .statusClr(we && idx == IO_STATUS && ioWtData[0]),
      .wtData   (ioWtData),
      .ctrl     (ctrl),
      .load     (load),
      .count    (count),
      .expired  (expired)
   );
   assign led_o = led;
   assign irq_o = expired && ctrl[CTRL_IRQ];
   assign ioRdData = !(hit && !ioWr)     ? '0 :
                     idx == IO_LED    ? 32'(led) :
                     idx == IO_SW     ? 32'(swSync) :
                     idx == IO_CTRL   ? {29'b0, ctrl} :
                     idx == IO_LOAD   ? load :
                     idx == IO_COUNT  ? count :
                     idx == IO_STATUS ? {31'b0, expired} : '0;
endmodule
